// File: rtl/iram_arbiter_if.sv
// Shared IRAM port bundle: fetch path, loader path and the
// block RAM pins, seen from the arbiter (slave) or its peers (master).
interface iram_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 16
);
   logic          f_req;
   logic [AW-1:0] f_addr;
   logic [DW-1:0] f_data;
   logic          f_valid;
   logic          l_req;
   logic [AW-1:0] l_addr;
   logic [DW-1:0] l_data;
   logic          l_ack;
   logic          load_mode;
   logic          cpu_stall;
   logic          wea;
   logic [AW-1:0] iaddr;
   logic [DW-1:0] idataout;
   logic [DW-1:0] idatain;

   modport slave (
      input  f_req, f_addr, l_req, l_addr, l_data,
      input  load_mode, idatain,
      output f_data, f_valid, l_ack, cpu_stall,
      output wea, iaddr, idataout
   );

   modport master (
      output f_req, f_addr, l_req, l_addr, l_data,
      output load_mode, idatain,
      input  f_data, f_valid, l_ack, cpu_stall,
      input  wea, iaddr, idataout
   );
endinterface

// File: rtl/iram_arbiter.sv
// Round-robin sequencer sharing the single IRAM port between
// instruction fetch (read) and the program loader (write).
module iram_arbiter #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input logic          clk,
   input logic          rst,
   iram_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RD_CAP,
      WR
   } state_t;

   state_t        state, state_n;
   logic          wea_q, wea_n;
   logic [AW-1:0] iaddr_q, iaddr_n;
   logic [DW-1:0] wdat_q, wdat_n;
   logic [DW-1:0] fdat_q, fdat_n;
   logic          fv_q, fv_n;
   logic          ack_q, ack_n;
   logic          last_q, last_n;
   logic          f_elig, l_elig, pick_l;

   // Completion pulses mask their own requester for one cycle.
   assign f_elig = bus.f_req & ~bus.load_mode & ~fv_q;
   assign l_elig = bus.l_req & ~ack_q;
   assign pick_l = l_elig & (~f_elig | ~last_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         wea_q   <= 1'b0;
         iaddr_q <= '0;
         wdat_q  <= '0;
         fdat_q  <= '0;
         fv_q    <= 1'b0;
         ack_q   <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state   <= state_n;
         wea_q   <= wea_n;
         iaddr_q <= iaddr_n;
         wdat_q  <= wdat_n;
         fdat_q  <= fdat_n;
         fv_q    <= fv_n;
         ack_q   <= ack_n;
         last_q  <= last_n;
      end
   end

   always_comb begin
      state_n = state;
      wea_n   = 1'b0;
      iaddr_n = iaddr_q;
      wdat_n  = wdat_q;
      fdat_n  = fdat_q;
      fv_n    = 1'b0;
      ack_n   = 1'b0;
      last_n  = last_q;
      unique case (state)
         IDLE: begin
            if (pick_l) begin
               iaddr_n = bus.l_addr;
               wdat_n  = bus.l_data;
               wea_n   = 1'b1;
               last_n  = 1'b1;
               state_n = WR;
            end else if (f_elig) begin
               iaddr_n = bus.f_addr;
               last_n  = 1'b0;
               state_n = RD_WAIT;
            end
         end
         RD_WAIT: state_n = RD_CAP;
         RD_CAP: begin
            fdat_n  = bus.idatain;
            fv_n    = 1'b1;
            state_n = IDLE;
         end
         WR: begin
            ack_n   = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.wea       = wea_q;
   assign bus.iaddr     = iaddr_q;
   assign bus.idataout  = wdat_q;
   assign bus.f_data    = fdat_q;
   assign bus.f_valid   = fv_q;
   assign bus.l_ack     = ack_q;
   assign bus.cpu_stall = bus.f_req & ~fv_q;

endmodule

// File: tb/tb_iram_arbiter.sv
// Bench for iram_arbiter: behavioural IRAM, shadow-memory reference
// model, directed scenarios followed by random single/contested traffic.
module tb_iram_arbiter;

   logic clk = 1'b0;
   logic rst;
   logic ram_init;

   always #5 clk = ~clk;

   iram_arbiter_if #(.AW(8), .DW(16)) bus ();

   iram_arbiter #(.AW(8), .DW(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] mem [256];
   logic [15:0] shadow [256];
   logic        mlast;

   int total = 0;
   int bad = 0;
   int fv_cnt = 0;
   int la_cnt = 0;
   int we_cnt = 0;
   int ns_cnt = 0;

   function automatic logic [15:0] seed(input int i);
      logic [31:0] v;
      v = i * 40503;
      return (i == 0) ? 16'h1234 : (v[15:0] ^ 16'h5A5A);
   endfunction

   // Synchronous-read block RAM, read-before-write.
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= seed(i);
      end else if (bus.wea) begin
         mem[bus.iaddr] <= bus.idataout;
      end
      bus.idatain <= mem[bus.iaddr];
   end

   always @(negedge clk) begin
      if (bus.f_valid) fv_cnt <= fv_cnt + 1;
      if (bus.l_ack) la_cnt <= la_cnt + 1;
      if (bus.wea) we_cnt <= we_cnt + 1;
      if (!bus.cpu_stall) ns_cnt <= ns_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.f_req = 1'b0;
      bus.l_req = 1'b0;
      bus.load_mode = 1'b0;
      bus.f_addr = '0;
      bus.l_addr = '0;
      bus.l_data = '0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
      tick();
      mlast = 1'b1;
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_wea"}, bus.wea, 0);
      chk({tag, "_iaddr"}, bus.iaddr, 0);
      chk({tag, "_wdat"}, bus.idataout, 0);
      chk({tag, "_fdata"}, bus.f_data, 0);
      chk({tag, "_fvalid"}, bus.f_valid, 0);
      chk({tag, "_lack"}, bus.l_ack, 0);
   endtask

   task automatic fetch(input logic [7:0] a, input string tag);
      int n;
      int w0;
      int s0;
      logic [15:0] exp;
      exp = shadow[a];
      w0 = we_cnt;
      s0 = ns_cnt;
      bus.f_addr = a;
      bus.f_req = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.f_valid && n < 20);
      chk({tag, "_lat"}, n, 3);
      chk({tag, "_data"}, bus.f_data, exp);
      chk({tag, "_stall"}, ns_cnt - s0, 0);
      bus.f_req = 1'b0;
      tick();
      chk({tag, "_pulse"}, bus.f_valid, 0);
      chk({tag, "_nowea"}, we_cnt - w0, 0);
      mlast = 1'b0;
   endtask

   task automatic load(input logic [7:0] a, input logic [15:0] d,
                       input string tag);
      int w0;
      w0 = we_cnt;
      bus.l_addr = a;
      bus.l_data = d;
      bus.l_req = 1'b1;
      tick();
      chk({tag, "_wea"}, bus.wea, 1);
      chk({tag, "_iaddr"}, bus.iaddr, a);
      chk({tag, "_wdat"}, bus.idataout, d);
      tick();
      chk({tag, "_ack"}, bus.l_ack, 1);
      chk({tag, "_wea0"}, bus.wea, 0);
      bus.l_req = 1'b0;
      tick();
      chk({tag, "_ack0"}, bus.l_ack, 0);
      chk({tag, "_wcnt"}, we_cnt - w0, 1);
      shadow[a] = d;
      mlast = 1'b1;
   endtask

   // Contested pair: the grant goes opposite the previous winner.
   task automatic both(input logic [7:0] fa, input logic [7:0] la,
                       input logic [15:0] ld, input string tag);
      logic first_load;
      logic [15:0] expf;
      logic [15:0] got;
      logic fdone, ldone, first_ev, seen;
      int n;
      first_load = ~mlast;
      expf = (first_load && fa == la) ? ld : shadow[fa];
      fdone = 1'b0;
      ldone = 1'b0;
      seen = 1'b0;
      first_ev = 1'b0;
      got = '0;
      bus.f_addr = fa;
      bus.l_addr = la;
      bus.l_data = ld;
      bus.f_req = 1'b1;
      bus.l_req = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         if (bus.f_valid && !fdone) begin
            fdone = 1'b1;
            got = bus.f_data;
            bus.f_req = 1'b0;
            if (!seen) first_ev = 1'b0;
            seen = 1'b1;
         end
         if (bus.l_ack && !ldone) begin
            ldone = 1'b1;
            bus.l_req = 1'b0;
            if (!seen) first_ev = 1'b1;
            seen = 1'b1;
         end
      end while (!(fdone && ldone) && n < 40);
      bus.f_req = 1'b0;
      bus.l_req = 1'b0;
      chk({tag, "_done"}, {fdone, ldone}, 2'b11);
      chk({tag, "_order"}, first_ev, first_load);
      chk({tag, "_data"}, got, expf);
      tick();
      chk({tag, "_quiet"}, {bus.f_valid, bus.l_ack}, 2'b00);
      shadow[la] = ld;
   endtask

   initial begin
      int n;
      int f0, l0, s0;
      logic [7:0] a;
      logic [15:0] d;

      rst = 1'b1;
      ram_init = 1'b1;
      idle_inputs();
      for (int i = 0; i < 256; i++) shadow[i] = seed(i);
      tick();
      tick();
      check_cleared("rst");
      chk("rst_stall", bus.cpu_stall, 0);
      ram_init = 1'b0;
      rst = 1'b0;
      tick();
      mlast = 1'b1;

      fetch(8'h00, "f00");
      load(8'h05, 16'hBEEF, "l05");
      fetch(8'h05, "f05");

      do_reset();
      both(8'h10, 8'h10, 16'hAAAA, "c1");
      both(8'h11, 8'h11, 16'h5555, "c2");

      bus.load_mode = 1'b1;
      bus.f_addr = 8'h20;
      bus.f_req = 1'b1;
      f0 = fv_cnt;
      s0 = ns_cnt;
      for (int k = 0; k < 4; k++) begin
         d = 16'($urandom);
         load(8'h30 + 8'(k), d, "lm");
      end
      chk("lm_nofv", fv_cnt - f0, 0);
      chk("lm_stall", ns_cnt - s0, 0);
      bus.load_mode = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.f_valid && n < 20);
      chk("lm_lat", n, 3);
      chk("lm_data", bus.f_data, shadow[8'h20]);
      bus.f_req = 1'b0;
      tick();
      mlast = 1'b0;

      for (int k = 1; k <= 3; k++) begin
         d = 16'($urandom);
         load(8'(k), d, "hpre");
      end
      f0 = fv_cnt;
      bus.f_addr = 8'h01;
      bus.f_req = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         n = 0;
         do begin
            tick();
            n++;
         end while (!bus.f_valid && n < 20);
         chk("held_per", n, (k == 1) ? 3 : 4);
         chk("held_data", bus.f_data, shadow[8'(k)]);
         bus.f_addr = 8'(k + 1);
      end
      bus.f_req = 1'b0;
      repeat (4) tick();
      chk("held_cnt", fv_cnt - f0, 3);
      mlast = 1'b0;

      bus.l_addr = 8'h40;
      bus.l_data = 16'hC0DE;
      bus.l_req = 1'b1;
      tick();
      chk("rwr_wea", bus.wea, 1);
      rst = 1'b1;
      #1;
      check_cleared("rwr");
      bus.l_req = 1'b0;
      #2;
      rst = 1'b0;
      l0 = la_cnt;
      repeat (4) tick();
      chk("rwr_noack", la_cnt - l0, 0);
      mlast = 1'b1;
      load(8'h40, 16'h4141, "rwr_l");
      fetch(8'h40, "rwr_f");

      bus.f_addr = 8'h41;
      bus.f_req = 1'b1;
      tick();
      rst = 1'b1;
      #1;
      check_cleared("rrd");
      bus.f_req = 1'b0;
      #2;
      rst = 1'b0;
      f0 = fv_cnt;
      repeat (4) tick();
      chk("rrd_nofv", fv_cnt - f0, 0);
      mlast = 1'b1;
      fetch(8'h41, "rrd_f");

      for (int k = 0; k < 30; k++) begin
         a = 8'($urandom_range(0, 15));
         d = 16'($urandom);
         case ($urandom_range(0, 2))
            0: fetch(a, "rnd_f");
            1: load(a, d, "rnd_l");
            default: both(8'($urandom_range(0, 15)), a, d, "rnd_c");
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
